// File: rtl/fifo_sync.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags,
// overflow/underflow pulses and selectable first-word-fall-through read.
module fifo_sync #(
  parameter int DATA_WIDTH          = 8,
  parameter int FIFO_DEPTH          = 16,
  parameter int ALMOST_FULL_THRESH  = 12,
  parameter int ALMOST_EMPTY_THRESH = 4,
  parameter bit FWFT                = 1'b0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              wr_en,
  input  logic                              rd_en,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic                              rd_valid,
  output logic                              full,
  output logic                              empty,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              overflow,
  output logic                              underflow
);
  localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH+1);
  localparam logic [ADDR_WIDTH-1:0]  PTR_LAST = ADDR_WIDTH'(FIFO_DEPTH-1);
  localparam logic [COUNT_WIDTH-1:0] CNT_FULL = COUNT_WIDTH'(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] CNT_AF   = COUNT_WIDTH'(ALMOST_FULL_THRESH);
  localparam logic [COUNT_WIDTH-1:0] CNT_AE   = COUNT_WIDTH'(ALMOST_EMPTY_THRESH);

  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic                   wr_acc, rd_acc;

  assign full         = (cnt_q == CNT_FULL);
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= CNT_AF);
  assign almost_empty = (cnt_q <= CNT_AE);
  assign count        = cnt_q;

  // Acceptance uses the registered flags, so a full FIFO still frees a slot
  // on a read but rejects a same-cycle write (and symmetrically when empty).
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is presented directly; forced to zero while empty.
    assign rd_data  = empty ? '0 : mem[rd_ptr];
    assign rd_valid = !empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem[rd_ptr];
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench: default FIFO (registered read), FWFT variant, and a depth-12
// variant used for sustained simultaneous traffic across pointer wraps.
module tb_fifo_sync;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: defaults, registered read
  logic [7:0] a_wd, a_rd;
  logic       a_we, a_re, a_rv, a_full, a_empty, a_af, a_ae, a_ov, a_un;
  logic [4:0] a_cnt;
  fifo_sync u_a (
    .clk(clk), .reset(reset), .wr_data(a_wd), .wr_en(a_we), .rd_en(a_re),
    .rd_data(a_rd), .rd_valid(a_rv), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
    .overflow(a_ov), .underflow(a_un));

  // Instance B: first-word-fall-through
  logic [7:0] b_wd, b_rd;
  logic       b_we, b_re, b_rv, b_full, b_empty, b_af, b_ae, b_ov, b_un;
  logic [4:0] b_cnt;
  fifo_sync #(.FWFT(1'b1)) u_b (
    .clk(clk), .reset(reset), .wr_data(b_wd), .wr_en(b_we), .rd_en(b_re),
    .rd_data(b_rd), .rd_valid(b_rv), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
    .overflow(b_ov), .underflow(b_un));

  // Instance C: depth 12, registered read
  logic [7:0] c_wd, c_rd;
  logic       c_we, c_re, c_rv, c_full, c_empty, c_af, c_ae, c_ov, c_un;
  logic [3:0] c_cnt;
  fifo_sync #(.FIFO_DEPTH(12), .ALMOST_FULL_THRESH(10), .ALMOST_EMPTY_THRESH(2)) u_c (
    .clk(clk), .reset(reset), .wr_data(c_wd), .wr_en(c_we), .rd_en(c_re),
    .rd_data(c_rd), .rd_valid(c_rv), .full(c_full), .empty(c_empty),
    .almost_full(c_af), .almost_empty(c_ae), .count(c_cnt),
    .overflow(c_ov), .underflow(c_un));

  initial begin
    reset = 1'b1;
    {a_wd, a_we, a_re} = '0;
    {b_wd, b_we, b_re} = '0;
    {c_wd, c_we, c_re} = '0;
    #12;
    chk("rst_count", 32'(a_cnt), 0);
    chk("rst_empty", 32'(a_empty), 1);
    chk("rst_aempty", 32'(a_ae), 1);
    chk("rst_full", 32'(a_full), 0);
    chk("rst_afull", 32'(a_af), 0);
    chk("rst_rvalid", 32'(a_rv), 0);
    chk("rst_rdata", 32'(a_rd), 0);
    chk("rst_ovf_unf", 32'({a_ov, a_un}), 0);
    chk("rst_b_rvalid", 32'(b_rv), 0);
    reset = 1'b0;

    // Fill A with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      a_we = 1'b1; a_wd = 8'(i);
      tick();
      chk("fill_count", 32'(a_cnt), i + 1);
      chk("fill_afull", 32'(a_af), (i + 1 >= 12) ? 1 : 0);
      chk("fill_full", 32'(a_full), (i + 1 == 16) ? 1 : 0);
    end
    a_wd = 8'h99;
    tick();
    chk("ovf_pulse", 32'(a_ov), 1);
    chk("ovf_count", 32'(a_cnt), 16);
    a_we = 1'b0;
    tick();
    chk("ovf_clear", 32'(a_ov), 0);

    // Drain A; data arrives one cycle after rd_en
    for (int i = 0; i < 16; i++) begin
      a_re = 1'b1;
      tick();
      chk("drain_data", 32'(a_rd), i);
      chk("drain_valid", 32'(a_rv), 1);
      chk("drain_count", 32'(a_cnt), 15 - i);
      chk("drain_aempty", 32'(a_ae), (15 - i <= 4) ? 1 : 0);
      chk("drain_empty", 32'(a_empty), (i == 15) ? 1 : 0);
    end
    tick();
    chk("unf_pulse", 32'(a_un), 1);
    chk("unf_valid", 32'(a_rv), 0);
    chk("unf_hold", 32'(a_rd), 8'h0F);
    chk("unf_count", 32'(a_cnt), 0);
    a_re = 1'b0;
    tick();
    chk("unf_clear", 32'(a_un), 0);

    // Boundary simultaneity at full
    for (int i = 0; i < 16; i++) begin
      a_we = 1'b1; a_wd = 8'(8'h20 + i);
      tick();
    end
    chk("bfull_full", 32'(a_full), 1);
    a_we = 1'b1; a_re = 1'b1; a_wd = 8'hEE;
    tick();
    chk("bfull_count", 32'(a_cnt), 15);
    chk("bfull_ovf", 32'(a_ov), 1);
    chk("bfull_data", 32'(a_rd), 8'h20);
    a_we = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("bfull_drain", 32'(a_rd), 8'h20 + i);
    end
    // Boundary simultaneity at empty
    a_we = 1'b1; a_re = 1'b1; a_wd = 8'h77;
    tick();
    chk("bempty_count", 32'(a_cnt), 1);
    chk("bempty_unf", 32'(a_un), 1);
    chk("bempty_valid", 32'(a_rv), 0);
    a_we = 1'b0;
    tick();
    chk("bempty_data", 32'(a_rd), 8'h77);
    chk("bempty_count0", 32'(a_cnt), 0);
    a_re = 1'b0;

    // FWFT: word falls through without rd_en
    b_we = 1'b1; b_wd = 8'hA5;
    tick();
    b_we = 1'b0;
    chk("fwft_valid", 32'(b_rv), 1);
    chk("fwft_data", 32'(b_rd), 8'hA5);
    tick();
    chk("fwft_hold", 32'(b_rd), 8'hA5);
    b_re = 1'b1;
    tick();
    b_re = 1'b0;
    chk("fwft_consumed", 32'(b_rv), 0);
    chk("fwft_empty", 32'(b_empty), 1);

    // Depth 12: prefill 5, then 40 cycles of read+write
    for (int i = 0; i < 5; i++) begin
      c_we = 1'b1; c_wd = 8'(i);
      tick();
    end
    chk("d12_pre_count", 32'(c_cnt), 5);
    for (int k = 0; k < 40; k++) begin
      c_we = 1'b1; c_re = 1'b1; c_wd = 8'(5 + k);
      tick();
      chk("d12_count", 32'(c_cnt), 5);
      chk("d12_order", 32'(c_rd), k);
    end
    c_we = 1'b0;
    for (int k = 40; k < 45; k++) begin
      tick();
      chk("d12_tail", 32'(c_rd), k);
    end
    c_re = 1'b0;
    chk("d12_empty", 32'(c_empty), 1);

    // Async reset mid-burst at count 9
    for (int i = 0; i < 9; i++) begin
      a_we = 1'b1; a_wd = 8'(8'h40 + i);
      tick();
    end
    chk("mid_count", 32'(a_cnt), 9);
    #1 reset = 1'b1;
    #1;
    chk("arst_count", 32'(a_cnt), 0);
    chk("arst_empty", 32'(a_empty), 1);
    chk("arst_aempty", 32'(a_ae), 1);
    chk("arst_full_af", 32'({a_full, a_af}), 0);
    chk("arst_rd", 32'({a_rv, a_rd}), 0);
    chk("arst_ovf_unf", 32'({a_ov, a_un}), 0);
    a_wd = 8'h5A;
    #1 reset = 1'b0;
    tick();
    a_we = 1'b0;
    chk("post_rst_count", 32'(a_cnt), 1);
    a_re = 1'b1;
    tick();
    a_re = 1'b0;
    chk("post_rst_data", 32'(a_rd), 8'h5A);
    chk("post_rst_valid", 32'(a_rv), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
